uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance among NUM_REQ byte-stream requesters.
- Round-robin arbitration with packet lock: a multi-byte message (terminated by last) is never interleaved with another requester's bytes.
- Sequences the transmitter: hands it one byte at a time, honours cts flow control, and waits for each frame to finish before issuing the next.
- Sits between host-side producers and the uart_tx inside the UART subsystem.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx among NUM_REQ byte streams.
// Optional idle-lock release is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cts,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 locked
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_evt
`endif
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] rr, owner, owner_inc, pick;
  logic            pick_found;
  logic            last_q;
  logic            accept;
  logic            release_lock;
  logic            tmo_hit;
  int unsigned     idx;

  // First valid requester at or above rr, wrapping.
  always_comb begin
    pick       = rr;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr) + i) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick       = idx[IDXW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  assign owner_inc = (32'(owner) == NUM_REQ - 1) ? '0 : owner + IDXW'(1);
  assign req_ready = (state == LOAD && cts && !tx_busy) ? (grant & req_valid) : '0;
  assign accept    = |req_ready;
  assign tx_start  = (state == START);
  assign locked    = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  assign tmo_hit = (state == LOAD) && !req_valid[owner] && (idle_cnt == CW'(TIMEOUT - 1));

  // A cts stall with the owner still valid neither counts nor clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tmo_hit;
      if (state != LOAD || accept || tmo_hit)
        idle_cnt <= '0;
      else if (!req_valid[owner])
        idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    release_lock = 1'b0;
    case (state)
      IDLE:      if (pick_found) state_nx = LOAD;
      LOAD: begin
        if (tmo_hit) begin
          state_nx     = IDLE;
          release_lock = 1'b1;
        end else if (accept) begin
          state_nx = START;
        end
      end
      START:     state_nx = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            state_nx     = IDLE;
            release_lock = 1'b1;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      rr      <= '0;
      tx_byte <= '0;
      last_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_found) begin
        owner <= pick;
        grant <= NUM_REQ'(1) << pick;
      end
      if (accept) begin
        tx_byte <= req_data[int'(owner)*8 +: 8];
        last_q  <= req_last[owner];
      end
      if (release_lock) begin
        grant <= '0;
        rr    <= owner_inc;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model. Defining UART_ARB_TIMEOUT_EN adds the timeout scenario.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           cts, tx_busy, tx_start, locked;
  logic [7:0]     tx_byte;
`ifdef UART_ARB_TIMEOUT_EN
  logic           timeout_evt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef UART_ARB_TIMEOUT_EN
  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cts(cts), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .grant(grant), .locked(locked),
    .timeout_evt(timeout_evt));
`else
  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cts(cts), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .grant(grant), .locked(locked));
`endif

  // Transmitter model: busy for busy_len cycles after each tx_start, logs (owner, byte).
  int         busy_len = 4;
  int         busy_cnt = 0;
  logic [7:0] started_byte = 8'h00;
  int         sent_q[$];
  int         exp_q[$];

  assign tx_busy = (busy_cnt != 0);

  function automatic int owner_of(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i] && r < 0) r = i;
    return r;
  endfunction

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      busy_cnt     <= busy_len;
      started_byte <= tx_byte;
      sent_q.push_back(owner_of(grant) * 256 + int'(tx_byte));
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Requester byte streams and reference arbitration state.
  logic [7:0] qd[N][$];
  logic       ql[N][$];
  int         model_rr = 0;
  logic [N-1:0] prev_gap = '0;

  // Packets are served whole, owners chosen round-robin starting at model_rr.
  task automatic build_expected();
    logic [7:0] md[N][$];
    logic       ml[N][$];
    int         rr;
    int         own;
    logic       fin;
    md = qd;
    ml = ql;
    rr = model_rr;
    exp_q.delete();
    forever begin
      own = -1;
      for (int k = 0; k < N; k++)
        if (own < 0 && md[(rr + k) % N].size() > 0) own = (rr + k) % N;
      if (own < 0) break;
      fin = 1'b0;
      while (!fin && md[own].size() > 0) begin
        fin = ml[own][0];
        exp_q.push_back(own * 256 + int'(md[own][0]));
        void'(md[own].pop_front());
        void'(ml[own].pop_front());
      end
      rr = (own + 1) % N;
    end
    model_rr = rr;
  endtask

  task automatic drive_from_queues(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0) begin
        req_data[8*i +: 8] = qd[i][0];
        req_last[i]        = ql[i][0];
        if (gaps && grant[i] && !prev_gap[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b0;
          prev_gap[i]  = 1'b1;
        end else begin
          req_valid[i] = 1'b1;
          prev_gap[i]  = 1'b0;
        end
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
        prev_gap[i]        = 1'b0;
      end
    end
  endtask

  task automatic run_traffic(input string name, input int max_cycles, input bit rand_cts, input bit gaps);
    int cyc = 0;
    bit done = 1'b0;
    bit all_empty;
    sent_q.delete();
    build_expected();
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      cts = rand_cts ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_from_queues(gaps);
      #1;
      checks++;
      if (((req_ready & (req_ready - 1'b1)) !== '0) || ((req_ready & ~grant) !== '0)) begin
        errors++;
        $display("FAIL %s ready_owner: req_ready=%b grant=%b", name, req_ready, grant);
      end
      if (tx_busy) begin
        checks++;
        if (tx_byte !== started_byte) begin
          errors++;
          $display("FAIL %s tx_byte_hold: tx_byte=%02h started=%02h", name, tx_byte, started_byte);
        end
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          void'(qd[i].pop_front());
          void'(ql[i].pop_front());
        end
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) all_empty = 1'b0;
      done = all_empty && !locked && !tx_busy && !tx_start;
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s drain_timeout: cycles=%0d limit=%0d", name, cyc, max_cycles);
    end
    checks++;
    if (sent_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, sent_q.size(), exp_q.size());
    end
    for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (sent_q[k] != exp_q[k]) begin
        errors++;
        $display("FAIL %s seq[%0d]: got req%0d byte %02h, expected req%0d byte %02h", name, k,
                 sent_q[k] / 256, sent_q[k] % 256, exp_q[k] / 256, exp_q[k] % 256);
      end
    end
  endtask

  task automatic wait_unlocked(input string name, input int limit);
    int cyc = 0;
    while (locked && cyc < limit) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL %s unlock: locked=%b after %0d cycles, required 0", name, locked, cyc);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    cts       = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    model_rr = 0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    cts       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %02h required 00", tx_byte); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b required 0000", grant); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b required 0", locked); end
    @(negedge clk);
    reset    = 1'b0;
    model_rr = 0;
  endtask

  task automatic test_single_byte();
    busy_len = 10;
    @(negedge clk);
    req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'hA5; req_last = 4'b0001; cts = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_c0_grant: got %b required 0000", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_c1_grant: got %b required 0001", grant); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_c1_ready: got %b required 0001", req_ready); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_c1_locked: got %b required 1", locked); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_c1_start: got %b required 0", tx_start); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_c2_start: got %b required 1", tx_start); end
    checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL single_c2_byte: got %02h required a5", tx_byte); end
    wait_unlocked("single", 40);
    // rr must now favour requester 1 over requester 0.
    @(negedge clk);
    req_valid = 4'b0011; req_data[15:8] = 8'h5A; req_last = 4'b0011;
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rr_advance: grant=%b required 0010", grant); end
    @(negedge clk);
    req_valid = '0;
    wait_unlocked("rr_advance", 40);
    model_rr = 2;
  endtask

  task automatic test_packet_lock();
    busy_len = 3;
    qd[2] = '{8'h2A, 8'h2B, 8'h2C}; ql[2] = '{1'b0, 1'b0, 1'b1};
    qd[1] = '{8'h11};               ql[1] = '{1'b1};
    run_traffic("packet_lock", 500, 1'b0, 1'b0);
  endtask

  task automatic test_flow_control();
    int bad = 0;
    busy_len = 4;
    @(negedge clk);
    req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h3C; req_last = 4'b0001; cts = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (req_ready !== '0 || tx_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cts_stall: %0d cycles with acceptance or start, required 0", bad); end
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL cts_stall_grant: got %b required 0001", grant); end
    @(negedge clk);
    cts = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cts_rise_ready: got %b required 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (tx_start !== 1'b1 || tx_byte !== 8'h3C) begin
      errors++; $display("FAIL cts_rise_start: tx_start=%b tx_byte=%02h required 1/3c", tx_start, tx_byte);
    end
    wait_unlocked("flow", 40);
    model_rr = 1;
  endtask

  task automatic test_reset_midop();
    int cyc = 0;
    busy_len = 8;
    @(negedge clk);
    req_valid = '1; req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req_last = '1; cts = 1'b1;
    do begin @(negedge clk); #1; cyc++; end while (!tx_busy && cyc < 20);
    checks++; if (!tx_busy) begin errors++; $display("FAIL midop_busy: tx_busy=%b required 1", tx_busy); end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midop_tx_start: got %b required 0", tx_start); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL midop_grant: got %b required 0000", grant); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midop_locked: got %b required 0", locked); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL midop_tx_byte: got %02h required 00", tx_byte); end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    model_rr  = 0;
  endtask

  task automatic test_round_robin();
    busy_len = 2;
    qd[0] = '{8'h10, 8'h14}; ql[0] = '{1'b1, 1'b1};
    qd[1] = '{8'h11};        ql[1] = '{1'b1};
    qd[2] = '{8'h12};        ql[2] = '{1'b1};
    qd[3] = '{8'h13};        ql[3] = '{1'b1};
    run_traffic("round_robin", 500, 1'b0, 1'b0);
  endtask

  task automatic test_random(input int iters);
    int npk, len;
    for (int it = 0; it < iters; it++) begin
      busy_len = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            qd[i].push_back(8'($urandom));
            ql[i].push_back(b == len - 1);
          end
        end
      end
      run_traffic($sformatf("random%0d", it), 5000, 1'b1, 1'b1);
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    apply_reset();
    busy_len = 3;
    @(negedge clk);
    req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h77; req_last = 4'b0000; cts = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0010; req_data[15:8] = 8'h88; req_last = 4'b0010;
    do begin @(negedge clk); #1; cyc++; end while (!tx_busy && cyc < 20);
    do begin @(negedge clk); #1; cyc++; end while (tx_busy && cyc < 40);
    checks++; if (tx_busy) begin errors++; $display("FAIL tmo_frame_done: tx_busy=%b required 0", tx_busy); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk); #1;
      checks++;
      if (timeout_evt !== (k == 17) || locked !== (k != 17)) begin
        errors++;
        $display("FAIL tmo_window[%0d]: timeout_evt=%b locked=%b required %b/%b",
                 k, timeout_evt, locked, (k == 17), (k != 17));
      end
    end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL tmo_next_grant: got %b required 0010", grant); end
    @(negedge clk);
    req_valid = '0;
    wait_unlocked("tmo_drain", 40);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_packet_lock();
    test_flow_control();
    test_reset_midop();
    test_round_robin();
    test_random(4);
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
